// File: rtl/mic_level_meter.sv
// Peak-hold mic level meter: per WINDOW samples, peak above MIDPOINT -> 0..16 level with one-step decay.
// Latency: raw_level 1 cycle, level/tester/level_valid 2 cycles after last window sample; samples outside ACCUM are dropped.
module mic_level_meter #(
    parameter int unsigned WINDOW   = 4000,
    parameter int unsigned MIDPOINT = 2048
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        hold,
    output logic [15:0] tester,
    output logic [4:0]  level,
    output logic [4:0]  raw_level,
    output logic        level_valid
);

    localparam logic [15:0] WIN = 16'(WINDOW);
    localparam logic [11:0] MID = 12'(MIDPOINT);

    typedef enum logic [1:0] {
        ACCUM,
        COMPUTE,
        UPDATE
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] peak_q, peak_d;
    logic [15:0] count_q, count_d;
    logic [4:0]  raw_q, raw_d;
    logic [4:0]  level_q, level_d;
    logic [15:0] tester_q, tester_d;
    logic        vld_q, vld_d;
    logic [11:0] amp;
    logic [5:0]  quant;

    function automatic logic [15:0] therm(input logic [4:0] k);
        therm = 16'((17'd1 << k) - 17'd1);
    endfunction

    always_comb begin
        state_d  = state_q;
        peak_d   = peak_q;
        count_d  = count_q;
        raw_d    = raw_q;
        level_d  = level_q;
        tester_d = tester_q;
        vld_d    = 1'b0;
        amp      = '0;
        quant    = '0;
        case (state_q)
            ACCUM: begin
                if (sample_valid) begin
                    if (sample > peak_q) peak_d = sample;
                    count_d = count_q + 16'd1;
                    if (count_d == WIN) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                amp   = (peak_q > MID) ? (peak_q - MID) : 12'd0;
                // Ceiling divide by 128; clamp covers a MIDPOINT low enough to allow >16.
                quant = 6'(({1'b0, amp} + 13'd127) >> 7);
                raw_d = (quant > 6'd16) ? 5'd16 : quant[4:0];
                state_d = UPDATE;
            end
            UPDATE: begin
                if (!hold) begin
                    level_d  = (raw_q >= level_q) ? raw_q : level_q - 5'd1;
                    tester_d = therm(level_d);
                    vld_d    = 1'b1;
                end
                peak_d  = '0;
                count_d = '0;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ACCUM;
            peak_q   <= '0;
            count_q  <= '0;
            raw_q    <= '0;
            level_q  <= '0;
            tester_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            peak_q   <= peak_d;
            count_q  <= count_d;
            raw_q    <= raw_d;
            level_q  <= level_d;
            tester_q <= tester_d;
            vld_q    <= vld_d;
        end
    end

    assign tester      = tester_q;
    assign level       = level_q;
    assign raw_level   = raw_q;
    assign level_valid = vld_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Bench for mic_level_meter (WINDOW=4): directed windows then randomized windows vs. a window-level model.
module tb_mic_level_meter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic        hold = 1'b0;
    logic [15:0] tester;
    logic [4:0]  level;
    logic [4:0]  raw_level;
    logic        level_valid;

    int n_vec = 0;
    int n_err = 0;
    int m_level = 0;

    mic_level_meter #(.WINDOW(4), .MIDPOINT(2048)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sample_valid(sample_valid),
        .sample      (sample),
        .hold        (hold),
        .tester      (tester),
        .level       (level),
        .raw_level   (raw_level),
        .level_valid (level_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int therm(input int k);
        return (1 << k) - 1;
    endfunction

    // One window of four samples; the model works on the whole window at once.
    task automatic run_window(input int s0, input int s1, input int s2, input int s3,
                              input bit h, input bit gaps, input bit junk);
        int s[4];
        int pk;
        int amp;
        int raw;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        pk = 0;
        hold = h;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clock);
                    sample_valid = 1'b0;
                    sample = 12'($urandom_range(0, 4095));
                end
            end
            @(negedge clock);
            sample_valid = 1'b1;
            sample = 12'(s[i]);
            if (s[i] > pk) pk = s[i];
        end
        amp = (pk > 2048) ? pk - 2048 : 0;
        raw = (amp + 127) / 128;
        if (!h) m_level = (raw >= m_level) ? raw : m_level - 1;

        @(negedge clock);
        sample_valid = junk;
        sample = 12'hFFF;
        check("valid_in_compute", level_valid, 0);
        @(negedge clock);
        check("raw_level", raw_level, raw);
        check("valid_early", level_valid, 0);
        sample_valid = junk;
        @(negedge clock);
        sample_valid = 1'b0;
        check("level", level, m_level);
        check("tester", tester, therm(m_level));
        check("level_valid", level_valid, h ? 0 : 1);
        @(negedge clock);
        check("valid_one_cycle", level_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lim;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_tester", tester, 0);
        check("rst_level", level, 0);
        check("rst_raw", raw_level, 0);
        check("rst_valid", level_valid, 0);

        run_window(2048, 3000, 2100, 2048, 0, 0, 0);
        run_window(2048, 4095, 2048, 2048, 0, 0, 0);
        run_window(2048, 2048, 2048, 2048, 0, 0, 1);
        run_window(2048, 2048, 2048, 2048, 0, 0, 0);
        run_window(2048, 2048, 2048, 2048, 0, 0, 1);
        run_window(100, 100, 100, 100, 0, 1, 0);

        // Bring level to 3, then hold across a full-scale window.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        m_level = 0;
        run_window(2048, 2348, 2000, 2048, 0, 0, 0);
        run_window(4095, 2048, 2048, 2048, 1, 0, 1);
        run_window(2048, 2048, 2048, 2048, 0, 0, 0);

        // Partial window discarded by reset; reset wins over valid/hold.
        @(negedge clock);
        sample_valid = 1'b1;
        sample = 12'hFFF;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        hold = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        sample_valid = 1'b0;
        hold = 1'b0;
        m_level = 0;
        check("mid_rst_level", level, 0);
        check("mid_rst_raw", raw_level, 0);
        check("mid_rst_tester", tester, 0);
        repeat (3) begin
            @(negedge clock);
            check("mid_rst_no_pulse", level_valid, 0);
        end
        run_window(2048, 2048, 2048, 2048, 0, 0, 1);
        run_window(2048, 2500, 2048, 2048, 0, 0, 1);

        for (int w = 0; w < 40; w++) begin
            lim = $urandom_range(1500, 4095);
            run_window($urandom_range(0, lim), $urandom_range(0, lim),
                       $urandom_range(0, lim), $urandom_range(0, lim),
                       ($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mic_level_meter.md
MIC_LEVEL_METER -- requirements
Module: mic_level_meter

Interface
REQ-001 Parameter WINDOW, default 4000, meaning samples per measurement window (legal 2..65535).
REQ-002 Parameter MIDPOINT, default 2048, meaning zero-signal code of the 12-bit unsigned mic sample.
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 sample_valid  input  1  one-cycle strobe; sample is valid this cycle.
REQ-006 sample  input  12  unsigned mic sample, MIDPOINT = silence.
REQ-007 hold  input  1  high: freeze displayed level; measurement continues.
REQ-008 tester  output  16  thermometer code of displayed level; level k sets bits [k-1:0], level 0 = 16'h0000.
REQ-009 level  output  5  displayed level, 0..16, after decay.
REQ-010 raw_level  output  5  level of the most recent window, no decay, no hold.
REQ-011 level_valid  output  1  one-cycle pulse when tester/level change or are refreshed.

Function
REQ-012 FSM states SHALL be ACCUM, COMPUTE, UPDATE; reset state ACCUM.
REQ-013 ACCUM: on sample_valid, peak register <= max(peak, sample); sample counter += 1.
REQ-014 ACCUM -> COMPUTE on the sample_valid that makes the count equal WINDOW; that sample SHALL be included in the peak.
REQ-015 COMPUTE (1 cycle): amplitude = peak - MIDPOINT if peak > MIDPOINT, else 0 (11 bits, no wrap).
REQ-016 COMPUTE: new level = ceil(amplitude/128) = (amplitude + 127) >> 7, using a 12-bit sum; result range 0..16; registered into raw_level.
REQ-017 UPDATE (1 cycle), hold low: if raw_level >= level then level <= raw_level; else level <= level - 1 (one-step decay per window).
REQ-018 UPDATE, hold low: tester <= thermometer(new level); level_valid high for exactly this one cycle.
REQ-019 UPDATE, hold high: level, tester unchanged; level_valid stays low; raw_level still updated.
REQ-020 UPDATE: peak <= 0, counter <= 0; next state ACCUM.
REQ-021 sample_valid asserted during COMPUTE or UPDATE SHALL be dropped (not counted, not in peak).
REQ-022 Latency: final window sample accepted at edge t -> raw_level visible after edge t+1, level/tester/level_valid after edge t+2.
REQ-023 Level never exceeds 16 and never decrements below 0; tester SHALL always be a valid thermometer code.
REQ-024 sample_valid held high continuously SHALL count one sample per accepted cycle in ACCUM.
REQ-025 Counter width 16 bits; no wrap since WINDOW <= 65535.

Reset
REQ-026 reset_n low at a rising edge SHALL force: state ACCUM, peak 0, counter 0, tester 16'h0000, level 0, raw_level 0, level_valid 0.
REQ-027 Reset mid-window or in COMPUTE/UPDATE SHALL discard the partial window; no level_valid pulse results from it.
REQ-028 Reset has priority over sample_valid and hold in the same cycle.

Verification
REQ-029 Reset: hold reset_n low 2 cycles, release -> tester 16'h0000, level 0, raw_level 0, level_valid 0.
REQ-030 WINDOW=4, samples 2048, 3000, 2100, 2048 -> amplitude 952, raw_level 8, level 8, tester 16'h00FF, level_valid one cycle exactly 2 edges after the 4th sample.
REQ-031 WINDOW=4, one sample 4095 in window -> level 16, tester 16'hFFFF; window of all 100 -> raw_level 0.
REQ-032 Decay: from level 16, three silent windows (all 2048) -> level 15, 14, 13; tester 16'h7FFF, 16'h3FFF, 16'h1FFF; level_valid per window.
REQ-033 Hold: level 3, hold=1, window with peak 4095 -> raw_level 16, tester stays 16'h0007, no level_valid; hold=0, next window peak 2048 -> level 2.
REQ-034 Reset mid-window: two 4095 samples, reset pulse, then four 2048 samples -> raw_level 0, level 0; sample_valid during COMPUTE/UPDATE does not shift the next window boundary.
